// File: rtl/lu_pkg.sv
// lu_pkg: shared constants and saturation helper for the LU array cells
package lu_pkg;
    localparam int DATA_SZ = 8;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction
endpackage

// File: rtl/pe_mult_stage.sv
// pe_mult_stage: registered signed multiplier stage with operand forwarding
module pe_mult_stage
    import lu_pkg::*;
#(
    parameter int SZ = DATA_SZ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            vIn,
    input  logic [SZ-1:0]   x,
    input  logic [SZ-1:0]   y,
    input  logic [SZ-1:0]   z,
    input  logic            sub,
    output logic [2*SZ-1:0] p1,
    output logic [SZ-1:0]   z1,
    output logic            s1,
    output logic            v1,
    output logic [SZ-1:0]   xOut,
    output logic [SZ-1:0]   yOut
);
    // Low 2*SZ bits of the product of sign-extended operands equal the signed product
    always_ff @(posedge clk) begin
        if (rst) begin
            p1 <= '0;
            z1 <= '0;
            s1 <= MODE_ADD;
            v1 <= 1'b0;
            xOut <= '0;
            yOut <= '0;
        end else if (en) begin
            p1 <= {{SZ{x[SZ-1]}}, x} * {{SZ{y[SZ-1]}}, y};
            z1 <= z;
            s1 <= sub;
            v1 <= vIn;
            xOut <= x;
            yOut <= y;
        end
    end
endmodule

// File: rtl/mac_pe_cell.sv
// mac_pe_cell: pipelined systolic MAC cell, zOut = z +/- (x*y >>> FRAC) with wrap/clamp and sticky overflow
module mac_pe_cell
    import lu_pkg::*;
#(
    parameter int SZ = DATA_SZ,
    parameter int FRAC = 0,
    parameter int SAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          vIn,
    input  logic [SZ-1:0] x,
    input  logic [SZ-1:0] y,
    input  logic [SZ-1:0] z,
    input  logic          sub,
    input  logic          clrOvf,
    output logic [SZ-1:0] zOut,
    output logic          vOut,
    output logic [SZ-1:0] xOut,
    output logic [SZ-1:0] yOut,
    output logic          ovf
);
    logic [2*SZ-1:0] p1;
    logic [SZ-1:0] z1;
    logic s1;
    logic v1;
    logic signed [2*SZ-1:0] q;
    logic [2*SZ:0] r;
    logic signed [63:0] rw;
    logic signed [63:0] rs;
    logic of;

    pe_mult_stage #(.SZ(SZ)) u_mult (
        .clk(clk),
        .rst(rst),
        .en(en),
        .vIn(vIn),
        .x(x),
        .y(y),
        .z(z),
        .sub(sub),
        .p1(p1),
        .z1(z1),
        .s1(s1),
        .v1(v1),
        .xOut(xOut),
        .yOut(yOut)
    );

    // r carries one guard bit over the product width so the add/sub is exact
    always_comb begin
        q = $signed(p1) >>> FRAC;
        r = s1 == MODE_SUB ? {{(SZ+1){z1[SZ-1]}}, z1} - {q[2*SZ-1], q}
                           : {{(SZ+1){z1[SZ-1]}}, z1} + {q[2*SZ-1], q};
        rw = {{(63-2*SZ){r[2*SZ]}}, r};
        rs = sat_s(rw, SZ);
        of = rs != rw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zOut <= '0;
            vOut <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (en) begin
                zOut <= SAT != 0 ? rs[SZ-1:0] : r[SZ-1:0];
                vOut <= v1;
            end
            ovf <= (en && v1 && of) || (ovf && !clrOvf);
        end
    end
endmodule
